alaw_expander_pipe: RTL and testbench



---
 rtl/alaw_expander_pipe.sv | 150 +++++++++++++++
 tb/tb_alaw_expander_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alaw_expander_pipe.sv
// alaw_expander_pipe: 3-stage pipelined compressed-code to linear expander
// with channel tag passthrough, valid/ready backpressure and symmetric
// saturation. Define SAT_COUNT_EN to add the 16-bit saturation event counter
// port sat_count.
module alaw_expander_pipe #(
   parameter int unsigned IN_W    = 15,
   parameter int unsigned EXP_W   = 7,
   parameter int unsigned OUT_W   = 24,
   parameter int unsigned BIAS_SH = 4,
   parameter int unsigned CHAN_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_code,
   input  logic [CHAN_W-1:0] in_chan,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [CHAN_W-1:0] out_chan,
   output logic              out_sat
`ifdef SAT_COUNT_EN
   ,
   output logic [15:0]       sat_count
`endif
);

   localparam int unsigned MANT_W = IN_W - EXP_W;
   localparam int unsigned PW     = OUT_W + MANT_W + 2;
   localparam logic [PW-1:0] ONE_P = PW'(1);
   localparam logic [PW-1:0] MAX_P = (ONE_P << (OUT_W - 1)) - ONE_P;

   logic              stall;

   logic              s1_valid_q, s1_valid_d;
   logic              s1_sign_q,  s1_sign_d;
   logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
   logic [MANT_W-1:0] s1_mant_q,  s1_mant_d;
   logic [CHAN_W-1:0] s1_chan_q,  s1_chan_d;
   logic [IN_W-1:0]   mag;

   logic              s2_valid_q, s2_valid_d;
   logic              s2_sign_q,  s2_sign_d;
   logic              s2_ovf_q,   s2_ovf_d;
   logic [PW-1:0]     s2_prod_q,  s2_prod_d;
   logic [PW-1:0]     s2_bias_q,  s2_bias_d;
   logic [CHAN_W-1:0] s2_chan_q,  s2_chan_d;
   logic [PW-1:0]     step;

   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  out_data_q,  out_data_d;
   logic [CHAN_W-1:0] out_chan_q,  out_chan_d;
   logic              out_sat_q,   out_sat_d;
   logic [PW-1:0]     sum;
   logic              sat;
   logic [OUT_W-1:0]  mag_o;

   assign stall     = out_valid_q && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_sat   = out_sat_q;

   // Next-state for all three stages: sign/magnitude split, step/bias products, sum and saturate.
   always_comb begin
      mag        = in_code[IN_W-1] ? (~in_code + IN_W'(1)) : in_code;
      s1_valid_d = in_valid && in_ready;
      s1_sign_d  = in_code[IN_W-1];
      s1_exp_d   = mag[EXP_W-1:0];
      s1_mant_d  = mag[IN_W-1:EXP_W];
      s1_chan_d  = in_chan;

      // Exponents this large overflow regardless of mantissa, so the products
      // are zeroed rather than computed at an unbounded width.
      s2_ovf_d   = (32'(s1_exp_q) + BIAS_SH + MANT_W + 1) >= (OUT_W + MANT_W + 2);
      step       = (s1_exp_q == '0) ? PW'(2) : (ONE_P << s1_exp_q);
      s2_prod_d  = s2_ovf_d ? '0 : step * (PW'(s1_mant_q) + ONE_P);
      s2_bias_d  = s2_ovf_d ? '0 : ((ONE_P << BIAS_SH) << s1_exp_q);
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_chan_d  = s1_chan_q;

      sum         = s2_prod_q + s2_bias_q;
      sat         = s2_ovf_q || (sum > MAX_P);
      mag_o       = sat ? MAX_P[OUT_W-1:0] : sum[OUT_W-1:0];
      out_data_d  = s2_sign_q ? ('0 - mag_o) : mag_o;
      out_sat_d   = sat;
      out_chan_d  = s2_chan_q;
      out_valid_d = s2_valid_q;
   end

   // Pipeline registers: cleared by reset, frozen as a whole while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= '0;
         s1_mant_q   <= '0;
         s1_chan_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_ovf_q    <= 1'b0;
         s2_prod_q   <= '0;
         s2_bias_q   <= '0;
         s2_chan_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (!stall) begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_mant_q   <= s1_mant_d;
         s1_chan_q   <= s1_chan_d;
         s2_valid_q  <= s2_valid_d;
         s2_sign_q   <= s2_sign_d;
         s2_ovf_q    <= s2_ovf_d;
         s2_prod_q   <= s2_prod_d;
         s2_bias_q   <= s2_bias_d;
         s2_chan_q   <= s2_chan_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_sat_q   <= out_sat_d;
      end
   end

`ifdef SAT_COUNT_EN
   logic [15:0] sat_count_q, sat_count_d;

   assign sat_count = sat_count_q;

   // Count saturated output transfers, sticking at all-ones.
   always_comb begin
      sat_count_d = sat_count_q;
      if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1))
         sat_count_d = sat_count_q + 16'd1;
   end

   // Saturation counter register.
   always_ff @(posedge clk) begin
      if (reset) sat_count_q <= '0;
      else       sat_count_q <= sat_count_d;
   end
`endif

endmodule

// File: tb/tb_alaw_expander_pipe.sv
// Self-checking bench for alaw_expander_pipe: directed vectors with literal
// expectations plus a scoreboard fed by an arithmetic model of the expansion.
module tb_alaw_expander_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] in_code;
   logic [1:0]  in_chan;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_data;
   logic [1:0]  out_chan;
   logic        out_sat;
`ifdef SAT_COUNT_EN
   logic [15:0] sat_count;
`endif

   int total = 0;
   int bad   = 0;
   int n_out = 0;

   typedef struct {
      logic [23:0] d;
      logic [1:0]  ch;
      logic        s;
   } exp_t;
   exp_t q[$];

   logic [14:0] codes [6] = '{15'h0001, 15'h0105, 15'h7ABC, 15'h0010, 15'h2233, 15'h4000};

   alaw_expander_pipe #(
      .IN_W(15), .EXP_W(7), .OUT_W(24), .BIAS_SH(4), .CHAN_W(2)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_chan(in_chan),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_chan(out_chan), .out_sat(out_sat)
`ifdef SAT_COUNT_EN
      , .sat_count(sat_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   // Linear value: sign from MSB, magnitude = |code| mod 2^15,
   // value = step*(mant+1) + 16*2^exp, clipped to +/-(2^23-1).
   function automatic logic [24:0] model(input logic [14:0] code);
      longint m, ex, mt, v;
      logic sat;
      m  = code[14] ? (32768 - longint'(code)) % 32768 : longint'(code);
      ex = m % 128;
      mt = m / 128;
      v  = 0;
      if (ex >= 40) sat = 1'b1;
      else begin
         v   = ((ex == 0) ? longint'(2) : (longint'(1) << ex)) * (mt + 1) + (longint'(16) << ex);
         sat = (v > 8388607);
      end
      if (sat) v = 8388607;
      return {sat, 24'(code[14] ? -v : v)};
   endfunction

   // Scoreboard: check every valid output cycle (including stalled ones), enqueue accepted inputs.
   always @(negedge clk) begin
      exp_t e;
      logic [24:0] mv;
      if (reset) q.delete();
      else begin
         if (out_valid) begin
            if (q.size() == 0) chk("sb_spurious", 1, 0);
            else begin
               e = q[0];
               chk("sb_data", out_data, e.d);
               chk("sb_chan", out_chan, e.ch);
               chk("sb_sat", out_sat, e.s);
               if (out_ready) begin
                  void'(q.pop_front());
                  n_out++;
               end
            end
         end
         if (in_valid && in_ready) begin
            mv   = model(in_code);
            e.d  = mv[23:0];
            e.s  = mv[24];
            e.ch = in_chan;
            q.push_back(e);
         end
      end
   end

   task automatic send_one(input logic [14:0] c, input logic [1:0] ch,
                           input logic [23:0] ed, input logic es, input string nm);
      int lat;
      @(posedge clk); #1;
      in_valid = 1'b1; in_code = c; in_chan = ch;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_lat"}, lat, 3);
      chk({nm, "_data"}, out_data, ed);
      chk({nm, "_sat"}, out_sat, es);
      chk({nm, "_chan"}, out_chan, ch);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, idx, stalls, seen;
      reset = 1'b1; in_valid = 1'b0; in_code = '0; in_chan = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_chan", out_chan, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_in_ready", in_ready, 1);

      send_one(15'h0000, 2'd0, 24'h000012, 1'b0, "zero");

      // back-to-back pair, one output per clock
      @(posedge clk); #1;
      in_valid = 1'b1; in_code = 15'h0081; in_chan = 2'd1;
      @(posedge clk); #1;
      in_code = 15'h7F7F; in_chan = 2'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b0_valid", out_valid, 1);
      chk("b2b0_data", out_data, 24'h000024);
      chk("b2b0_chan", out_chan, 2'd1);
      @(posedge clk); #1;
      chk("b2b1_valid", out_valid, 1);
      chk("b2b1_data", out_data, 24'hFFFFDC);
      chk("b2b1_chan", out_chan, 2'd2);
      @(posedge clk); #1;
      chk("b2b_idle", out_valid, 0);

      send_one(15'h0012, 2'd3, 24'h440000, 1'b0, "exp18");
      send_one(15'h0014, 2'd1, 24'h7FFFFF, 1'b1, "exp20");
      send_one(15'h7FEC, 2'd2, 24'h800001, 1'b1, "negsat");
      send_one(15'h4000, 2'd0, 24'hFFFEEE, 1'b0, "mostneg");

      // stream of 6 with a 4-cycle output stall in the middle
      base = n_out; idx = 0; stalls = 0;
      for (int c = 0; c < 60 && idx < 6; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 4 && c < 8);
         in_valid  = 1'b1;
         in_code   = codes[idx];
         in_chan   = 2'(idx);
         #1;
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            stalls++;
         end
         if (in_ready) idx++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 20 && (q.size() != 0 || out_valid); c++) begin
         @(posedge clk); #1;
      end
      chk("stream_sent", idx, 6);
      chk("stream_count", n_out - base, 6);
      chk("stall_seen", stalls > 0, 1);

      // reset with three samples in flight
      @(posedge clk); #1;
      in_valid = 1'b1; in_code = 15'h0105; in_chan = 2'd1;
      @(posedge clk); #1;
      in_code = 15'h0014; in_chan = 2'd2;
      @(posedge clk); #1;
      in_code = 15'h7F7F; in_chan = 2'd3;
      @(posedge clk); #1;
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_valid", out_valid, 0);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      chk("midrst_quiet", seen, 0);
      chk("midrst_in_ready", in_ready, 1);

`ifdef SAT_COUNT_EN
      chk("satcnt_cleared", sat_count, 0);
      send_one(15'h0014, 2'd0, 24'h7FFFFF, 1'b1, "sc0");
      send_one(15'h7FEC, 2'd1, 24'h800001, 1'b1, "sc1");
      send_one(15'h0012, 2'd2, 24'h440000, 1'b0, "sc_nosat");
      send_one(15'h0014, 2'd3, 24'h7FFFFF, 1'b1, "sc2");
      chk("satcnt_three", sat_count, 3);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("satcnt_reset", sat_count, 0);
`endif

      chk("sb_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
